// File: rtl/cordic_sin_cos_rotate.sv
// ============================================================================
// Module   : cordic_sin_cos_rotate
// Brief    : Iterative rotation-mode CORDIC, Q16.4 degree angle in, Q4.16 sin/cos out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cordic_sin_cos_rotate #(
    parameter int ITER  = 12,
    parameter int W_ANG = 20,
    parameter int W_OUT = 20,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [W_ANG-1:0] z_input,
    output logic                    busy,
    output logic                    done,
    output logic signed [W_OUT-1:0] sin_res,
    output logic signed [W_OUT-1:0] cos_res,
    output logic                    range_err
);

    localparam int c_WX = W_OUT + GUARD;
    localparam int c_WI = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [W_ANG-1:0] c_Z180 = W_ANG'(2880);
    localparam logic signed [W_ANG-1:0] c_Z90  = W_ANG'(1440);
    localparam logic signed [c_WX-1:0]  c_K    = c_WX'(39797) <<< GUARD;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [c_WX-1:0]  r_x;
    logic signed [c_WX-1:0]  r_y;
    logic signed [W_ANG-1:0] r_z;
    logic [c_WI-1:0]         r_iter;
    logic                    r_neg;
    logic                    r_err_lat;

    logic signed [W_OUT-1:0] r_sin;
    logic signed [W_OUT-1:0] r_cos;
    logic                    r_done;
    logic                    r_range_err;

    logic signed [W_ANG-1:0] w_z_clamp;
    logic signed [W_ANG-1:0] w_z_fold;
    logic                    w_clamp;
    logic                    w_neg;
    logic signed [c_WX-1:0]  w_xs;
    logic signed [c_WX-1:0]  w_ys;
    logic signed [W_ANG-1:0] w_atan;
    logic signed [W_OUT-1:0] w_x_rnd;
    logic signed [W_OUT-1:0] w_y_rnd;

    // arctan(2^-i) in Q16.4 degrees
    function automatic logic signed [W_ANG-1:0] f_atan(input int i);
        case (i)
            0:       f_atan = W_ANG'(720);
            1:       f_atan = W_ANG'(425);
            2:       f_atan = W_ANG'(225);
            3:       f_atan = W_ANG'(114);
            4:       f_atan = W_ANG'(57);
            5:       f_atan = W_ANG'(29);
            6:       f_atan = W_ANG'(14);
            7:       f_atan = W_ANG'(7);
            8:       f_atan = W_ANG'(4);
            9:       f_atan = W_ANG'(2);
            10:      f_atan = W_ANG'(1);
            default: f_atan = '0;
        endcase
    endfunction

    // Saturate to +-180 deg, then fold the outer quadrants into +-90 deg;
    // a folded angle yields negated sin and cos.
    always_comb begin
        w_z_clamp = z_input;
        w_clamp   = 1'b0;
        if (z_input > c_Z180) begin
            w_z_clamp = c_Z180;
            w_clamp   = 1'b1;
        end else if (z_input < -c_Z180) begin
            w_z_clamp = -c_Z180;
            w_clamp   = 1'b1;
        end

        w_z_fold = w_z_clamp;
        w_neg    = 1'b0;
        if (w_z_clamp > c_Z90) begin
            w_z_fold = w_z_clamp - c_Z180;
            w_neg    = 1'b1;
        end else if (w_z_clamp < -c_Z90) begin
            w_z_fold = w_z_clamp + c_Z180;
            w_neg    = 1'b1;
        end
    end

    assign w_xs   = r_x >>> r_iter;
    assign w_ys   = r_y >>> r_iter;
    assign w_atan = f_atan(int'(r_iter));

    generate
        if (GUARD > 0) begin : g_round
            localparam logic signed [c_WX-1:0] c_HALF = c_WX'(1) <<< (GUARD - 1);
            assign w_x_rnd = W_OUT'((r_x + c_HALF) >>> GUARD);
            assign w_y_rnd = W_OUT'((r_y + c_HALF) >>> GUARD);
        end else begin : g_no_round
            assign w_x_rnd = r_x;
            assign w_y_rnd = r_y;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_ROTATE;
            S_ROTATE: if (r_iter == c_WI'(ITER - 1)) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_iter    <= '0;
            r_neg     <= 1'b0;
            r_err_lat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x       <= c_K;
                        r_y       <= '0;
                        r_z       <= w_z_fold;
                        r_neg     <= w_neg;
                        r_err_lat <= w_clamp;
                        r_iter    <= '0;
                    end
                end
                S_ROTATE: begin
                    if (!r_z[W_ANG-1]) begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan;
                    end else begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan;
                    end
                    r_iter <= r_iter + c_WI'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sin       <= '0;
            r_cos       <= '0;
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_FINISH) begin
                r_done      <= 1'b1;
                r_range_err <= r_err_lat;
                r_sin       <= r_neg ? -w_y_rnd : w_y_rnd;
                r_cos       <= r_neg ? -w_x_rnd : w_x_rnd;
            end
        end
    end

    assign done      = r_done;
    assign sin_res   = r_sin;
    assign cos_res   = r_cos;
    assign range_err = r_range_err;

endmodule

`default_nettype wire

// File: doc/cordic_sin_cos_rotate.md
Name: cordic_sin_cos_rotate

Overview:
- Rotation-mode CORDIC: the inverse direction of the vectoring-mode tan-inverse block. It takes an angle and returns sin and cos. The tan-inverse block goes from coordinates to an angle.
- The angle uses the same signed Q16.4 degree format as the tan-inverse block and its arctan(2^-i) LUT.
- Iterative datapath: one micro-rotation per clock, with a start/busy/done handshake.
- Sits beside cordic_tan_inverse in the angle-processing path. It regenerates unit vectors from computed angles.

Parameters:
- ITER, 12, number of micro-rotations. Legal range 1..12; the Q16.4 LUT entries are zero beyond i=10.
- W_ANG, 20, angle width, signed Q16.4 degrees.
- W_OUT, 20, sin/cos width, signed Q4.16.
- GUARD, 2, extra LSBs carried internally on x/y.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request pulse. Sampled only when busy=0.
- z_input  in  W_ANG  angle in degrees, Q16.4 (30 deg = 480).
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when sin_res/cos_res update.
- sin_res  out  W_OUT  sin(z), Q4.16 (1.0 = 65536).
- cos_res  out  W_OUT  cos(z), Q4.16.
- range_err  out  1  high when the latched angle was outside ±180 deg and saturated. Updated with done.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, range_err=0; sin_res, cos_res=0; iteration counter=0. Reset mid-conversion aborts the conversion with no done pulse.
- FSM states: IDLE, ROTATE, FINISH.
- IDLE: on start=1, latch z_input and go to ROTATE; busy=1 from the next cycle.
- ROTATE: one iteration i per clock, i=0..ITER-1. After i=ITER-1, go to FINISH.
- FINISH: lasts one cycle. Sign-correct and register outputs, then return to IDLE.
- Latency: start sampled at edge 0 → done=1 and outputs valid from edge ITER+1 (13 cycles at default).
  - busy is high during cycles 1..ITER+1.
  - busy falls at the same edge done rises.
  - Outputs hold until the next done.
- start while busy=1 is ignored; z_input changes during busy have no effect.
- start in the done cycle (busy=0) is accepted, giving back-to-back throughput of ITER+1 cycles.
- Range pre-processing at latch time (180 deg = 2880, 90 deg = 1440):
  - z > 2880 or z < -2880: clamp to ±2880 and set the range_err latch.
  - z > 1440: z' = z - 2880, negate flag=1.
  - z < -1440: z' = z + 2880, negate flag=1.
  - Otherwise z' = z, negate flag=0.
  - z = ±1440 is not folded.
- Init: x0 = K = round(0.6072529*2^(16+GUARD)), i.e. 39797 scaled by 2^GUARD; y0 = 0; z = z'.
- Iteration i: d = +1 if z ≥ 0, else -1.
  - x ← x - d·(y>>>i)
  - y ← y + d·(x>>>i)
  - z ← z - d·LUT[i]
  - All updates use old values; shifts are arithmetic.
- LUT (Q16.4 deg): 720, 425, 225, 114, 57, 29, 14, 7, 4, 2, 1, 0.
- Internal x/y width is W_OUT+GUARD. No wrap occurs, since |x|,|y| ≤ 1.65·K.
- FINISH: round off GUARD bits (add half-LSB, arithmetic shift). If the negate flag is set, negate both results. Write sin_res=y and cos_res=x.

Test Plan:
- Reset during ROTATE (assert rst at cycle 5 of a conversion):
  - busy/done/outputs go to 0 immediately, without waiting for a clock edge.
  - No done pulse follows.
  - The next start completes normally.
- z_input=480 (30 deg), start pulse:
  - done exactly 13 cycles later.
  - sin_res=32768±128, cos_res=56756±128, range_err=0.
- z_input=0 → sin_res=0±128, cos_res=65536±128. Then z_input=-720 (-45 deg) → sin_res=-46341±128, cos_res=46341±128.
- z_input=1920 (120 deg) → sin_res=56756±128, cos_res=-32768±128. Then z_input=-2880 (-180 deg) → sin_res=0±128, cos_res=-65536±128, range_err=0.
- z_input=3200 (200 deg) → clamped to 180 deg: sin_res=0±128, cos_res=-65536±128, range_err=1.
- Handshake:
  - Pulse start again at cycles 3 and 7 of a conversion; both are ignored and only one done occurs.
  - Assert start in the done cycle with z_input=1440 → accepted, second done 13 cycles later with sin_res=65536±128, cos_res=0±128.
  - Sweep -2880..2880 in steps of 16 and check each result against a real-valued model within ±128.
